ramb16_s4_ctrl: RTL and testbench
=================================

RAMB16_S4_CTRL -- requirements
Module: ramb16_s4_ctrl

Interface
REQ-001 Parameter CLR_VAL, default 4'h0: data word written to every address during a clear sweep.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, synchronous, active-low.
REQ-004 CMD_VALID  input  1  command request.
REQ-005 CMD_READY  output  1  command accepted when CMD_VALID && CMD_READY at a rising edge.
REQ-006 CMD_WE  input  1  1 = write, 0 = read.
REQ-007 CMD_ADDR  input  12  word address, 0x000-0xFFF.
REQ-008 CMD_DATA  input  4  write data.
REQ-009 RSP_VALID  output  1  read response available.
REQ-010 RSP_READY  input  1  response consumed when RSP_VALID && RSP_READY at a rising edge.
REQ-011 RSP_DATA  output  4  read data, held stable while RSP_VALID && !RSP_READY.
REQ-012 CLR_REQ  input  1  start a clear sweep.
REQ-013 CLR_BUSY  output  1  high for the whole sweep.
REQ-014 RAM_ADDR / RAM_DI / RAM_EN / RAM_WE  output  12/4/1/1  drive the 4096x4 block-RAM port.
REQ-015 RAM_DO  input  4  block-RAM read data, valid one cycle after an enabled read edge.

Function
REQ-016 The FSM SHALL have two states: RUN and CLEAR.
REQ-017 RAM port outputs SHALL be combinational from the accepted command: RAM_EN=1, RAM_WE=CMD_WE, RAM_ADDR=CMD_ADDR, RAM_DI=CMD_DATA on an accept cycle; otherwise RAM_EN=0, RAM_WE=0.
REQ-018 A read accepted in cycle t SHALL set an in-flight flag for cycle t+1, push RAM_DO into the response buffer at the end of t+1, and raise RSP_VALID in cycle t+2.
REQ-019 The response buffer SHALL be 2-entry FIFO; responses return in acceptance order, none dropped or duplicated.
REQ-020 In RUN: CMD_READY = !CLR_REQ && ((count + inflight < 2) || (RSP_VALID && RSP_READY)); the same rule SHALL apply to reads and writes. This gives one read per cycle while RSP_READY=1.
REQ-021 Writes SHALL produce no response.
REQ-022 Clear start: CLR_REQ=1 in RUN SHALL enter CLEAR at the next edge with the address counter at 0; no command is accepted in that cycle.
REQ-023 In CLEAR: CMD_READY=0, CLR_BUSY=1, RAM_EN=1, RAM_WE=1, RAM_DI=CLR_VAL, RAM_ADDR=counter; the counter increments once per cycle.
REQ-024 Clear end: after the cycle writing 0xFFF, the FSM SHALL return to RUN, giving exactly 4096 CLEAR cycles; the counter wraps to 0.
REQ-025 CLR_REQ SHALL be ignored in CLEAR.
REQ-026 In CLEAR, a read in flight at entry SHALL complete, and buffered responses SHALL continue to drain.
REQ-027 Buffer push and pop in the same cycle SHALL leave count unchanged.

Reset
REQ-028 While RST_N=0 at an edge: state=RUN, counter=0, inflight=0, buffer empty.
REQ-029 While RST_N is low, CMD_READY=0 and RAM_EN=0.
REQ-030 After reset: RSP_VALID=0, CLR_BUSY=0, RSP_DATA=4'h0.
REQ-031 Reset during CLEAR SHALL abandon the sweep; the sweep is not resumed.

Structure
REQ-032 A shared package SHALL hold ADDR_W=12, DATA_W=4, DEPTH=4096 and the state enum {RUN, CLEAR}.
REQ-033 The 2-entry response FIFO SHALL be one sub-module, ramb16_s4_rsp_buf.

Verification
REQ-034 Write 0xA to 0x123, then read 0x123 -> RSP_VALID two cycles after read acceptance, RSP_DATA=0xA.
REQ-035 Reads of 0x000-0x003 back-to-back with RSP_READY=1 -> CMD_READY stays 1; four responses in order, one per cycle.
REQ-036 RSP_READY=0 with continuous reads -> CMD_READY drops after 2 outstanding; raise RSP_READY -> both responses delivered in order, then throughput resumes.
REQ-037 CLR_VAL=4'h5, pulse CLR_REQ -> CLR_BUSY high exactly 4096 cycles with CMD_READY=0; then reads of 0x000 and 0xFFF return 0x5.
REQ-038 CLR_REQ and CMD_VALID (read) in the same cycle -> CMD_READY=0 and no read issued; the sweep starts.
REQ-039 RST_N=0 when the counter reaches 0x800 -> next cycle CLR_BUSY=0, RSP_VALID=0; 0x800 and above keep their prior data, and 0x7FF reads CLR_VAL.

Source files
------------

// File: rtl/ramb16_s4_ctrl_pkg.sv
// Shared sizes, FSM state type and address helper for the RAMB16_S4 controller.
package ramb16_s4_ctrl_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 4096;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic logic is_last_addr(input logic [ADDR_W-1:0] addr);
        return (addr == {ADDR_W{1'b1}});
    endfunction

endpackage

// File: rtl/ramb16_s4_rsp_buf.sv
// Two-entry read-response FIFO; the head entry is held until it is popped.
module ramb16_s4_rsp_buf
    import ramb16_s4_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic              valid,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] mem_r [2];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        count_r;

    // Storage, pointers and occupancy; push+pop together keeps the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_r[0] <= {DATA_W{1'b0}};
            mem_r[1] <= {DATA_W{1'b0}};
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;
    assign valid = (count_r != 2'd0);
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/ramb16_s4_ctrl.sv
// Command/response front end for a 4096x4 block RAM with a full-array clear sweep.
module ramb16_s4_ctrl
    import ramb16_s4_ctrl_pkg::*;
#(
    parameter logic [DATA_W-1:0] CLR_VAL = 4'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    output logic              ram_en,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_do
);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_nxt_s;
    logic              inflight_r;
    logic              inflight_nxt_s;
    logic [1:0]        count_s;
    logic              pop_s;
    logic              accept_s;
    logic              cmd_ready_s;

    assign pop_s = rsp_valid && rsp_ready;

    // Next-state, acceptance and RAM port drive.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        inflight_nxt_s = 1'b0;
        cmd_ready_s    = 1'b0;
        accept_s       = 1'b0;
        ram_en         = 1'b0;
        ram_we         = 1'b0;
        ram_addr       = cmd_addr;
        ram_di         = cmd_data;
        case (state_r)
            RUN: begin
                // A pop this cycle frees a slot, so reads stream at full rate.
                if (rst_n && !clr_req) begin
                    cmd_ready_s = (({1'b0, count_s} + {2'b00, inflight_r}) < 3'd2) || pop_s;
                end else begin
                    cmd_ready_s = 1'b0;
                end
                accept_s = cmd_valid && cmd_ready_s;
                if (accept_s) begin
                    ram_en         = 1'b1;
                    ram_we         = cmd_we;
                    inflight_nxt_s = !cmd_we;
                end else begin
                    ram_en         = 1'b0;
                    ram_we         = 1'b0;
                end
                if (clr_req) begin
                    state_nxt_s = CLEAR;
                    cnt_nxt_s   = {ADDR_W{1'b0}};
                end else begin
                    state_nxt_s = RUN;
                end
            end
            CLEAR: begin
                ram_en    = rst_n;
                ram_we    = rst_n;
                ram_di    = CLR_VAL;
                ram_addr  = cnt_r;
                cnt_nxt_s = cnt_r + 12'd1;
                if (is_last_addr(cnt_r)) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = CLEAR;
                end
            end
            default: begin
                state_nxt_s = RUN;
            end
        endcase
    end

    // State, sweep counter and read-in-flight flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= RUN;
            cnt_r      <= {ADDR_W{1'b0}};
            inflight_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            inflight_r <= inflight_nxt_s;
        end
    end

    ramb16_s4_rsp_buf u_rsp_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_r),
        .push_data (ram_do),
        .pop       (pop_s),
        .count     (count_s),
        .valid     (rsp_valid),
        .head      (rsp_data)
    );

    assign cmd_ready = cmd_ready_s;
    assign clr_busy  = (state_r == CLEAR);

endmodule

// File: tb/tb_ramb16_s4_ctrl.sv
// Directed + random bench for ramb16_s4_ctrl against a shadow-memory/response-queue model.
module tb_ramb16_s4_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [11:0] cmd_addr = 12'h000;
    logic [3:0]  cmd_data = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [3:0]  rsp_data;
    logic        clr_req = 1'b0;
    logic        clr_busy;
    logic [11:0] ram_addr;
    logic [3:0]  ram_di;
    logic        ram_en;
    logic        ram_we;
    logic [3:0]  ram_do = 4'h0;

    always #5 clk = ~clk;

    ramb16_s4_ctrl #(.CLR_VAL(4'h5)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .clr_req(clr_req), .clr_busy(clr_busy), .ram_addr(ram_addr), .ram_di(ram_di),
        .ram_en(ram_en), .ram_we(ram_we), .ram_do(ram_do)
    );

    // Block RAM: synchronous write, registered read output.
    logic [3:0] ram [4096];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_di;
            else        ram_do <= ram[ram_addr];
        end
    end

    // Reference model: expected memory contents and outstanding read results.
    typedef struct { int vis; logic [3:0] d; } rsp_t;
    logic [3:0] shadow [4096];
    rsp_t q[$];
    int cyc = 0;
    int clr_left = 0;
    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic we, input logic [11:0] a, input logic [3:0] d,
                         input logic rr, input logic clr, input logic rst);
        logic exp_valid, exp_pop, exp_ready, acc, in_clr;
        int caddr;
        cmd_valid = v; cmd_we = we; cmd_addr = a; cmd_data = d;
        rsp_ready = rr; clr_req = clr; rst_n = rst;
        caddr = 0;
        @(negedge clk);
        in_clr    = (clr_left != 0);
        exp_valid = (q.size() > 0) && (q[0].vis <= cyc);
        exp_pop   = exp_valid && rr;
        exp_ready = rst && !in_clr && !clr && ((q.size() < 2) || exp_pop);
        acc       = v && exp_ready;
        chk("cmd_ready", cmd_ready, exp_ready);
        chk("ram_en", ram_en, rst && (in_clr || acc));
        if (rst) begin
            chk("rsp_valid", rsp_valid, exp_valid);
            chk("clr_busy", clr_busy, in_clr);
        end
        if (rst && in_clr) begin
            caddr = 4096 - clr_left;
            chk("clr_we", ram_we, 1'b1);
            chk("clr_addr", ram_addr, caddr);
            chk("clr_di", ram_di, 4'h5);
        end
        if (acc) begin
            chk("acc_we", ram_we, we);
            chk("acc_addr", ram_addr, a);
            if (we) chk("acc_di", ram_di, d);
        end
        if (rst && exp_pop) begin
            chk("rsp_data", rsp_data, q[0].d);
            q.delete(0);
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            q.delete();
            clr_left = 0;
        end else if (in_clr) begin
            shadow[caddr] = 4'h5;
            clr_left--;
        end else begin
            if (acc) begin
                if (we) shadow[a] = d;
                else    q.push_back('{vis: cyc + 2, d: shadow[a]});
            end
            if (clr) clr_left = 4096;
        end
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i]    = 4'($urandom);
            shadow[i] = ram[i];
        end
        repeat (3) cycle(1'b1, 1'b0, 12'h000, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_clr_busy", clr_busy, 1'b0);
        chk("rst_rsp_data", rsp_data, 4'h0);

        // Write then read back with two-cycle latency
        cycle(1'b1, 1'b1, 12'h123, 4'hA, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 12'h123, 4'h0, 1'b1, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 1'b0, 1'b1);

        // Back-to-back reads at full throughput
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 12'(i), 4'h0, 1'b1, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 1'b0, 1'b1);

        // Backpressure then release
        repeat (6) cycle(1'b1, 1'b0, 12'($urandom_range(0, 4095)), 4'h0, 1'b0, 1'b0, 1'b1);
        repeat (8) cycle(1'b1, 1'b0, 12'($urandom_range(0, 4095)), 4'h0, 1'b1, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 1'b0, 1'b1);

        // Random mixed traffic on a small address window
        repeat (400) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           12'($urandom_range(0, 15)), 4'($urandom),
                           ($urandom_range(0, 3) != 0), 1'b0, 1'b1);

        // Clear with a read in flight and a read competing with clr_req
        cycle(1'b1, 1'b0, 12'h010, 4'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 12'h020, 4'h0, 1'b0, 1'b1, 1'b1);
        repeat (4096) cycle(1'($urandom_range(0, 1)), 1'b0, 12'($urandom), 4'h0,
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        cycle(1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 12'h000, 4'h0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 12'hFFF, 4'h0, 1'b1, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 1'b0, 1'b1);

        // Reset mid-sweep abandons the clear
        cycle(1'b1, 1'b1, 12'h7FF, 4'h3, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 12'h800, 4'hC, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 12'h801, 4'hC, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 12'hFFF, 4'hC, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 1'b1, 1'b1);
        repeat (2048) cycle(1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("midclr_busy", clr_busy, 1'b0);
        chk("midclr_rsp_valid", rsp_valid, 1'b0);
        cycle(1'b1, 1'b0, 12'h7FF, 4'h0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 12'h800, 4'h0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 12'h801, 4'h0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 12'hFFF, 4'h0, 1'b1, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 1'b0, 1'b1);
        chk("final_drain", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
